rr_decode_arbiter: RTL and testbench
====================================

// Module: rr_decode_arbiter
// PURPOSE
//  8-way round-robin arbiter sharing one decoded resource (an 8-line select bus) among 8 requesters.
//  Picks one requester, drives a registered 3-bit index plus its one-hot decode as the grant, and holds it until release.
//  Sits between requesting masters and the 8-way select datapath; drives gnt_idx as its select code.
// PARAMETERS
//  HOLD_MAX  16  max consecutive grant cycles while others wait; 0 = unlimited hold (no forced rotation)
//  CNT_W     5   hold-counter width; must satisfy 2**CNT_W > HOLD_MAX
// PORTS
//  clk        in   1  single clock, all state updates on posedge
//  rst        in   1  synchronous, active-high reset
//  req        in   8  request per requester; held high until served
//  done       in   1  release pulse from current owner (ignored when gnt_valid=0)
//  gnt        out  8  one-hot grant, registered; all-zero when idle
//  gnt_idx    out  3  binary index of owner; gnt == (8'b1 << gnt_idx) whenever gnt_valid
//  gnt_valid  out  1  high while a grant is held
//  ptr        out  3  current round-robin priority pointer (debug/observability)
// BEHAVIOUR
//  - Reset (rst=1 at a posedge): state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, ptr=3'd0, hold_cnt=0. Reset wins over every other event, including mid-grant.
//  - States: IDLE (no owner), GRANT (owner = gnt_idx).
//  - Winner search: first set bit of req scanning ptr, ptr+1, ... ptr+7, indices mod 8 (7 wraps to 0).
//  - IDLE: if |req, next edge -> GRANT with the winner; gnt_valid=1, gnt=onehot(winner), hold_cnt=0.
//    - Latency: req sampled at edge t gives a grant visible after edge t+1 (one cycle).
//    - If req == 0, stay IDLE.
//  - GRANT, release condition = done | ~req[gnt_idx] | timeout.
//    - timeout = (HOLD_MAX != 0) && (hold_cnt == HOLD_MAX-1) && |(req & ~gnt).
//  - GRANT, no release: hold owner; hold_cnt increments, saturating at HOLD_MAX-1.
//  - GRANT, release: ptr <= gnt_idx+1 (mod 8); search restarts from the new ptr using this cycle's req with the owner's bit masked off.
//    - If another winner exists: switch directly at the next edge, no idle gap; hold_cnt=0.
//    - Otherwise -> IDLE, gnt=0, gnt_valid=0. The released owner can re-win from IDLE one cycle later.
//  - Only the owner requesting: timeout never fires; grant held indefinitely until done or req drop.
//  - done and owner req-drop in the same cycle count as a single release.
//  - done while IDLE: ignored.
//  - ptr changes only on release, never on the initial grant from IDLE.
//  - gnt and gnt_idx never change without passing through a release or reset.
//  - gnt is always one-hot or zero; never multi-hot.
// STRUCTURE
//  - Shared package (arb_pkg):
//    - state encoding localparams ST_IDLE=1'b0, ST_GRANT=1'b1
//    - constant N_REQ=8, IDX_W=3
//  - One sub-module: rr_pick8, combinational. Inputs (req[7:0], ptr[2:0]); outputs (any, idx[2:0]).
//    - Implementation: rotate right by ptr, fixed-priority find-first, add ptr back mod 8.
//  - Top level holds the FSM, hold counter, ptr register and registered one-hot decode of gnt_idx.
// TESTING
//  1. Reset: rst=1 for 2 cycles with req=8'hFF
//     -> gnt=0, gnt_valid=0, ptr=0 throughout; after release, gnt=8'h01 one cycle later.
//  2. Rotation: req=8'hFF, pulse done every 3rd cycle
//     -> gnt_idx sequence 0,1,2,...,7,0 (wrap checked); ptr trails owner by +1.
//  3. Sparse/wrap: ptr=6, req=8'b0010_0001 on owner release
//     -> next owner idx 0 (wraps past 7), then 5; never idx 6/7.
//  4. Timeout: HOLD_MAX=4, req=8'h03, owner 0 never sends done
//     -> owner 1 granted after exactly 4 grant cycles; with req=8'h01 only, owner 0 held for 50+ cycles.
//  5. Simultaneous events: done and owner req-drop together
//     -> single release, one pointer advance. Back-to-back release with others waiting -> zero-cycle gap.
//  6. Reset mid-grant: rst asserted while gnt=8'h10
//     -> next edge gnt=0, ptr=0; after reset, req=8'h10 -> gnt=8'h10 one cycle later.

Source files
------------

// File: rtl/rr_decode_arbiter_pkg.sv
// Shared constants, state encoding and decode helper for the round-robin
// select arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_decode_arbiter_if.sv
// Requester-side bus of the arbiter: requests/release in, grant and pointer out.
interface rr_decode_arbiter_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic [IDX_W-1:0] ptr;

  modport master (output req, done, input gnt, gnt_idx, gnt_valid, ptr);
  modport slave  (input req, done, output gnt, gnt_idx, gnt_valid, ptr);
endinterface

// File: rtl/rr_decode_arbiter_pick8.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o
);
  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  // rot[g] is the request g slots after ptr; index arithmetic wraps mod 8
  for (genvar g = 0; g < N_REQ; g++) begin : g_rot
    localparam logic [IDX_W-1:0] G = IDX_W'(g);
    assign rot[g] = req_i[G + ptr_i];
  end

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (rot[i]) off = IDX_W'(i);
  end

  assign any_o = |req_i;
  assign idx_o = ptr_i + off;
endmodule

// File: rtl/rr_decode_arbiter.sv
// 8-way round-robin arbiter: registered index + one-hot grant held until
// release (done, owner request drop, or hold timeout with others waiting).
module rr_decode_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input logic                clk,
  input logic                rst,
  rr_decode_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic [N_REQ-1:0] others;
  logic [IDX_W-1:0] next_ptr, pick_ptr, pick_idx;
  logic             pick_any, timeout, rel;

  // gnt_q is zero in IDLE, so one picker serves both the initial grant and
  // the hand-off search with the owner masked off.
  assign others   = bus.req & ~gnt_q;
  assign next_ptr = idx_q + IDX_W'(1);
  assign pick_ptr = (state_q == S_GRANT) ? next_ptr : ptr_q;
  assign timeout  = (HOLD_MAX != 0) && (hold_q == HOLD_LAST) && (|others);
  assign rel      = bus.done || !bus.req[idx_q] || timeout;

  rr_pick8 u_pick (
    .req_i (others),
    .ptr_i (pick_ptr),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d = S_GRANT;
          idx_d   = pick_idx;
          hold_d  = '0;
        end
      end
      S_GRANT: begin
        if (rel) begin
          ptr_d = next_ptr;
          if (pick_any) begin
            idx_d  = pick_idx;
            hold_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    gnt_d = (state_d == S_GRANT) ? onehot(idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = (state_q == S_GRANT);
  assign bus.ptr       = ptr_q;
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: directed vector table, hand-written timeout
// sequences, then random traffic against a behavioural model.
module tb_rr_decode_arbiter;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_decode_arbiter_if bus ();

  rr_decode_arbiter #(.HOLD_MAX(HOLD), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rs;
    logic [7:0] req;
    logic       d;
    logic       ev;
    logic [2:0] ei;
    logic [2:0] ep;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // model: owner (-1 = none), pointer, grant cycles elapsed for the owner
  int m_own  = -1;
  int m_ptr  = 0;
  int m_hold = 0;

  logic [7:0] rq;

  function automatic vec_t mk(input logic rs, input logic [7:0] r, input logic d,
                              input logic ev, input logic [2:0] ei, input logic [2:0] ep);
    vec_t v;
    v.rs = rs; v.req = r; v.d = d; v.ev = ev; v.ei = ei; v.ep = ep;
    return v;
  endfunction

  function automatic int search(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic model_step(input logic rs, input logic [7:0] r, input logic d);
    logic [7:0] oth;
    int         w;
    bit         rl;
    if (rs) begin
      m_own = -1; m_ptr = 0; m_hold = 0;
    end else if (m_own < 0) begin
      w = search(r, m_ptr);
      if (w >= 0) begin m_own = w; m_hold = 1; end
    end else begin
      oth = r;
      oth[m_own] = 1'b0;
      rl = d || !r[m_own] || (m_hold >= HOLD && oth != 8'h00);
      if (rl) begin
        m_ptr = (m_own + 1) % 8;
        w = search(oth, m_ptr);
        if (w >= 0) begin m_own = w; m_hold = 1; end
        else m_own = -1;
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic cycle(input logic rs, input logic [7:0] r, input logic d);
    rst      = rs;
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    model_step(rs, r, d);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic ev, input logic [2:0] ei, input logic [2:0] ep);
    logic [7:0] eg;
    bit         ok;
    eg = ev ? (8'h01 << ei) : 8'h00;
    ok = (bus.gnt_valid === ev) && (bus.gnt === eg) && (bus.ptr === ep) &&
         (!ev || bus.gnt_idx === ei);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got valid=%0b gnt=%h idx=%0d ptr=%0d, want valid=%0b gnt=%h idx=%0d ptr=%0d",
               nm, bus.gnt_valid, bus.gnt, bus.gnt_idx, bus.ptr, ev, eg, ei, ep);
    end
  endtask

  task automatic check_model(input string nm);
    check(nm, m_own >= 0, (m_own >= 0) ? 3'(m_own) : 3'd0, 3'(m_ptr));
  endtask

  initial begin
    rst = 1'b1; bus.req = 8'h00; bus.done = 1'b0;

    // reset held with all requesting, then release
    tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 3'd0));
    tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 3'd0));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, 3'd0, 3'd0));
    // rotation: done every third cycle, owners 0..7 then wrap to 0
    for (int k = 1; k <= 8; k++) begin
      tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, 3'(k - 1), 3'(k - 1)));
      tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, 3'(k - 1), 3'(k - 1)));
      tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 3'(k % 8), 3'(k % 8)));
    end
    // sparse wrap: owner 5 releases with ptr->6, req 0010_0001 -> 0 then 5
    tbl.push_back(mk(1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 3'd1));
    tbl.push_back(mk(1'b0, 8'h21, 1'b1, 1'b1, 3'd0, 3'd6));
    tbl.push_back(mk(1'b0, 8'h21, 1'b1, 1'b1, 3'd5, 3'd1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 3'd6));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 3'd6));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 3'd6));
    // grant from IDLE keeps ptr; done + req-drop is a single advance
    tbl.push_back(mk(1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 3'd6));
    tbl.push_back(mk(1'b0, 8'h08, 1'b1, 1'b1, 3'd3, 3'd5));
    tbl.push_back(mk(1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 3'd5));
    tbl.push_back(mk(1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 3'd4));
    // reset mid-grant, then re-grant
    tbl.push_back(mk(1'b1, 8'h10, 1'b0, 1'b0, 3'd0, 3'd0));
    tbl.push_back(mk(1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 3'd0));

    @(negedge clk);
    foreach (tbl[i]) begin
      cycle(tbl[i].rs, tbl[i].req, tbl[i].d);
      check($sformatf("table[%0d]", i), tbl[i].ev, tbl[i].ei, tbl[i].ep);
      if (tbl[i].rs) begin
        n_vec++;
        if (bus.gnt_idx !== 3'd0) begin
          n_err++;
          $display("FAIL reset_idx[%0d]: got gnt_idx=%0d, want 0", i, bus.gnt_idx);
        end
      end
    end

    // timeout: owner 0 keeps requesting, owner 1 waits -> exactly 4 grant cycles
    cycle(1'b1, 8'h00, 1'b0);
    check("to_reset", 1'b0, 3'd0, 3'd0);
    for (int c = 0; c < HOLD; c++) begin
      cycle(1'b0, 8'h03, 1'b0);
      check($sformatf("to_hold[%0d]", c), 1'b1, 3'd0, 3'd0);
    end
    cycle(1'b0, 8'h03, 1'b0);
    check("to_switch", 1'b1, 3'd1, 3'd1);
    // lone owner never times out
    cycle(1'b0, 8'h01, 1'b0);
    check("lone_grant", 1'b1, 3'd0, 3'd2);
    for (int c = 0; c < 60; c++) begin
      cycle(1'b0, 8'h01, 1'b0);
      check($sformatf("lone_hold[%0d]", c), 1'b1, 3'd0, 3'd2);
    end
    // saturated hold count: a newcomer forces rotation at the next edge
    cycle(1'b0, 8'h03, 1'b0);
    check("sat_timeout", 1'b1, 3'd1, 3'd1);

    // random traffic against the model
    cycle(1'b1, 8'h00, 1'b0);
    check_model("rand_reset");
    rq = 8'h00;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      cycle($urandom_range(0, 63) == 0, rq, $urandom_range(0, 3) == 0);
      check_model($sformatf("rand[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
